// File: rtl/bmp_stream_writer_if.sv
// bmp_stream_writer_if: pixel-FIFO read side, byte-FIFO write side and frame pulse
interface bmp_stream_writer_if #(parameter int FIFO_DATA_WIDTH = 32);
  logic [FIFO_DATA_WIDTH-1:0] fifo_in_dout;
  logic fifo_in_empty;
  logic fifo_in_rd_en;
  logic [7:0] fifo_out_din;
  logic fifo_out_full;
  logic fifo_out_wr_en;
  logic frame_done;
  modport master (
    input fifo_in_dout, fifo_in_empty, fifo_out_full,
    output fifo_in_rd_en, fifo_out_din, fifo_out_wr_en, frame_done
  );
  modport slave (
    output fifo_in_dout, fifo_in_empty, fifo_out_full,
    input fifo_in_rd_en, fifo_out_din, fifo_out_wr_en, frame_done
  );
endinterface

// File: rtl/bmp_stream_writer.sv
// bmp_stream_writer: serializes {B,G,R,x} words into a 24-bit BMP byte stream with row padding.
// Define BMP_STREAM_WRITER_HEADER_EN to prefix each frame with the 54-byte BMP header.
module bmp_stream_writer #(
  parameter int FIFO_DATA_WIDTH = 32,
  parameter int BMP_WIDTH = 720,
  parameter int BMP_HEIGHT = 540
) (
  input logic clock,
  input logic reset,
  bmp_stream_writer_if.master bus
);
  localparam int ROW_BYTES = 3 * BMP_WIDTH;
  localparam int PAD = (4 - ROW_BYTES % 4) % 4;
  localparam int STRIDE = ROW_BYTES + PAD;
  localparam int IMG = STRIDE * BMP_HEIGHT;
  localparam int CW = $clog2(BMP_WIDTH + 1);
  localparam int RW = $clog2(BMP_HEIGHT + 1);
  localparam logic [CW-1:0] LAST_COL = CW'(BMP_WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(BMP_HEIGHT - 1);
  localparam logic [1:0] LAST_PAD = 2'(PAD - 1);
`ifdef BMP_STREAM_WRITER_HEADER_EN
  typedef enum logic [1:0] {S_HDR, S_PIX, S_PAD} state_t;
  localparam state_t S_START = S_HDR;
  // little-endian fields packed so header byte k sits at bits [8k+7:8k]
  localparam logic [431:0] HDR = {
    32'd0, 32'd0, 32'd2835, 32'd2835, 32'(IMG), 32'd0, 16'd24, 16'd1,
    32'(BMP_HEIGHT), 32'(BMP_WIDTH), 32'd40, 32'd54, 32'd0, 32'(54 + IMG), 8'h4D, 8'h42
  };
  logic [5:0] hdr_idx_q;
`else
  typedef enum logic [1:0] {S_PIX, S_PAD} state_t;
  localparam state_t S_START = S_PIX;
`endif
  state_t state_q;
  logic [1:0] byte_idx_q, pad_cnt_q;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic wr, third, row_done_pix, pad_done, row_done, last_row, unused_lsbs;
  logic [7:0] pix_byte, ctl_byte;
  assign unused_lsbs = ^bus.fifo_in_dout[FIFO_DATA_WIDTH-25:0];
  assign wr = !reset && !bus.fifo_out_full && (state_q != S_PIX || !bus.fifo_in_empty);
  assign third = state_q == S_PIX && byte_idx_q == 2'd2;
  assign row_done_pix = third && col_q == LAST_COL;
  assign pad_done = state_q == S_PAD && pad_cnt_q == LAST_PAD;
  assign row_done = (PAD == 0) ? row_done_pix : pad_done;
  assign last_row = row_q == LAST_ROW;
  assign pix_byte = byte_idx_q == 2'd0 ? bus.fifo_in_dout[FIFO_DATA_WIDTH-1 -: 8] :
                    byte_idx_q == 2'd1 ? bus.fifo_in_dout[FIFO_DATA_WIDTH-9 -: 8] :
                                         bus.fifo_in_dout[FIFO_DATA_WIDTH-17 -: 8];
`ifdef BMP_STREAM_WRITER_HEADER_EN
  assign ctl_byte = state_q == S_HDR ? HDR[{hdr_idx_q, 3'b000} +: 8] : 8'h00;
`else
  assign ctl_byte = 8'h00;
`endif
  assign bus.fifo_out_wr_en = wr;
  assign bus.fifo_out_din = !wr ? 8'h00 : state_q == S_PIX ? pix_byte : ctl_byte;
  assign bus.fifo_in_rd_en = wr && third;
  assign bus.frame_done = wr && row_done && last_row;
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_START;
      byte_idx_q <= 2'd0;
      pad_cnt_q <= 2'd0;
      col_q <= '0;
      row_q <= '0;
`ifdef BMP_STREAM_WRITER_HEADER_EN
      hdr_idx_q <= 6'd0;
`endif
    end else if (wr) begin
`ifdef BMP_STREAM_WRITER_HEADER_EN
      if (state_q == S_HDR) begin
        hdr_idx_q <= hdr_idx_q == 6'd53 ? 6'd0 : hdr_idx_q + 6'd1;
        if (hdr_idx_q == 6'd53) state_q <= S_PIX;
      end
`endif
      if (state_q == S_PIX) begin
        byte_idx_q <= third ? 2'd0 : byte_idx_q + 2'd1;
        if (third) col_q <= col_q == LAST_COL ? '0 : col_q + CW'(1);
        if (row_done_pix && PAD != 0) state_q <= S_PAD;
      end
      if (state_q == S_PAD) pad_cnt_q <= pad_done ? 2'd0 : pad_cnt_q + 2'd1;
      // row end: the last pixel byte without padding, else the last pad byte
      if (row_done) begin
        row_q <= last_row ? '0 : row_q + RW'(1);
        state_q <= last_row ? S_START : S_PIX;
      end
    end
  end
endmodule

// File: doc/bmp_stream_writer.md
# bmp_stream_writer

Streaming BMP serializer on the output side of `dut_system`. It pops 32-bit pixel words `{B,G,R,8'h00}` from a first-word-fall-through FIFO, the same packing the input loader produces from a 24-bit BMP. It writes a byte stream to a byte-wide FIFO: a 54-byte BMP header, then pixel bytes in file order with per-row zero padding. The resulting byte stream can be dumped directly to a viewable `.bmp` file, so processed frames can be checked visually and byte-compared against golden images.

## Interface
- `FIFO_DATA_WIDTH`, 32, input word width; only bits [31:8] carry pixel data.
- `BMP_WIDTH`, 720, pixels per row.
- `BMP_HEIGHT`, 540, rows per frame.
- `clock` input 1: single clock; all logic on its rising edge.
- `reset` input 1: synchronous, active-high.
- `fifo_in_dout` input FIFO_DATA_WIDTH: head word of the pixel FIFO; valid whenever `fifo_in_empty`=0.
- `fifo_in_empty` input 1: pixel FIFO empty.
- `fifo_in_rd_en` output 1: pops the pixel FIFO head this cycle.
- `fifo_out_din` output 8: byte to write.
- `fifo_out_full` input 1: byte FIFO full.
- `fifo_out_wr_en` output 1: writes `fifo_out_din` this cycle.
- `frame_done` output 1: one-cycle pulse on the cycle the last byte of a frame is written.

## Operation
- Derived constants:
  - `ROW_BYTES` = 3·BMP_WIDTH.
  - `PAD` = (4 − ROW_BYTES mod 4) mod 4.
  - `STRIDE` = ROW_BYTES + PAD.
  - `IMG` = STRIDE·BMP_HEIGHT.
  - All header fields are 32-bit little-endian unless noted.
- State machine has states HDR, PIX, PAD.
  - Reset enters HDR and clears all counters: `hdr_idx`, `byte_idx` (0..2), `col`, `row`, `pad_cnt`.
- HDR emits header bytes 0..53 in order:
  - "B", "M".
  - File size 54+IMG.
  - 4 reserved zero bytes.
  - Pixel-data offset 54.
  - DIB header size 40.
  - BMP_WIDTH.
  - BMP_HEIGHT.
  - Planes 1 (16-bit).
  - Bits per pixel 24 (16-bit).
  - Compression 0.
  - IMG.
  - X and Y resolution, 2835 each.
  - Colors used 0.
  - Important colors 0.
  - After byte 53 → PIX.
- PIX emits bytes from the head word:
  - `byte_idx` 0 → [31:24], 1 → [23:16], 2 → [15:8]; [7:0] is discarded.
  - A byte is written only when `fifo_in_empty`=0 and `fifo_out_full`=0.
  - The write of `byte_idx`=2 also asserts `fifo_in_rd_en` in the same cycle and advances `col`.
  - At `col`=BMP_WIDTH−1: go to PAD if PAD≠0; otherwise advance `row` and stay in PIX.
- PAD emits PAD bytes of 0x00, gated only by `fifo_out_full`, then advances `row` → PIX.
- End of frame: the last byte is the final pad byte, or the final pixel byte when PAD=0.
  - That write pulses `frame_done`.
  - The block then returns to HDR with all counters cleared and starts the next frame.
- `fifo_out_wr_en`, `fifo_out_din`, and `fifo_in_rd_en` are combinational from state, counters, `fifo_in_dout`, and the two flags. This makes overflow and underflow impossible.
- `fifo_out_din` is 0x00 whenever `fifo_out_wr_en`=0.

## Timing
- Reset:
  - Outputs are forced to 0 during any cycle with `reset`=1: `fifo_in_rd_en`=0, `fifo_out_wr_en`=0, `fifo_out_din`=0x00, `frame_done`=0.
  - The first header byte may be written on the first cycle after `reset` deasserts.
  - Reset mid-frame abandons the partial frame. The partially consumed word is not popped.
- Throughput: one byte per cycle when unstalled; one input word per 3 cycles.
  - Frame length is 54+IMG bytes (IMG+54 cycles minimum).
- Latency: zero-cycle combinational path from `fifo_in_dout` to `fifo_out_din`.
- Stalls:
  - `fifo_out_full`=1 freezes all state and counters.
  - `fifo_in_empty`=1 freezes PIX only. HDR and PAD proceed regardless of the input FIFO.
- Simultaneous full/empty deassertion: the write occurs in the first cycle where both conditions allow it.
- `fifo_in_rd_en` is never asserted while `fifo_in_empty`=1, nor without a same-cycle byte write.

## Configuration
- `BMP_STREAM_WRITER_HEADER_EN`:
  - Defined: header emitted as above.
  - Undefined: HDR is not compiled. Reset and frame wrap go directly to PIX, and frame length is IMG bytes. Raw-pixel mode is used for byte-compare against headerless golden dumps.

## Test plan
- BMP_WIDTH=2, BMP_HEIGHT=2, header on, FIFO preloaded with 0xAABBCC00, 0x11223300, 0x44556600, 0x77889900, `fifo_out_full`=0 → output in 70 consecutive cycles:
  - Header bytes 0..5 = 42 4D 46 00 00 00.
  - Bytes 18..25 = 02 00 00 00 02 00 00 00.
  - Then AA BB CC 11 22 33 00 00 44 55 66 77 88 99 00 00.
  - `frame_done` pulses only on cycle 70.
- Default 720×540, header on → 1166454 bytes. Bytes 2..5 = 76 CC 11 00; PAD=0 so no pad bytes appear. A second frame starts immediately with "BM".
- Toggle `fifo_out_full` every other cycle mid-pixel → identical byte sequence, no write while full, `fifo_in_rd_en` only alongside a third-byte write.
- Hold `fifo_in_empty`=1 for 10 cycles inside a row → 0 writes during the hold. The header and pad phases still complete while empty.
- Assert `reset` after 30 bytes of a frame → outputs 0 during reset, next byte written is 0x42, and the unfinished word remains in the FIFO.
- Header macro undefined, 2×2 → the 16 pixel/pad bytes only, `frame_done` on cycle 16.
